// File: rtl/prim_fifo_wr_arb_pkg.sv
// Package for prim_fifo_wr_arb.
// Holds the arbiter FSM state type shared by the top level and anything that
// wants to decode it. No ports.
package prim_fifo_wr_arb_pkg;

    // IDLE arbitrates every cycle; LOCK holds the grant for a packet in progress.
    typedef enum logic {
        StIdle = 1'b0,
        StLock = 1'b1
    } arb_state_e;

endpackage

// File: rtl/prim_fifo_wr_arb_if.sv
// Handshake bundle between NumReq producers, the write arbiter and a FIFO
// write port.
//   req_valid/req_ready/req_data/req_last : per-requester beat handshake,
//                                           requester k data at [k*Width +: Width]
//   fifo_wvalid/fifo_wready/fifo_wdata    : FIFO write port
// Modports: master = producers + FIFO side (drives requests and wready),
//           slave  = the arbiter.
interface prim_fifo_wr_arb_if #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned Width  = 16
);
    logic [NumReq-1:0]       req_valid;
    logic [NumReq-1:0]       req_ready;
    logic [NumReq*Width-1:0] req_data;
    logic [NumReq-1:0]       req_last;
    logic                    fifo_wvalid;
    logic                    fifo_wready;
    logic [Width-1:0]        fifo_wdata;

    modport master (
        output req_valid, req_data, req_last, fifo_wready,
        input  req_ready, fifo_wvalid, fifo_wdata
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_wready,
        output req_ready, fifo_wvalid, fifo_wdata
    );
endinterface

// File: rtl/prim_rr_pick.sv
// Combinational rotate-priority search.
//   req_i : request vector
//   ptr_i : index with highest priority this cycle
//   idx_o : first set request at or after ptr_i (mod NumReq); 0 if none
//   any_o : at least one request is set
// The wrap uses a compare, so NumReq need not be a power of two.
module prim_rr_pick #(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    int unsigned cand;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!any_o && req_i[cand[IdxW-1:0]]) begin
                any_o = 1'b1;
                idx_o = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/prim_fifo_wr_arb.sv
// Round-robin write-port arbiter with packet locking in front of a
// prim_fifo_sync. A requester that wins with last=0 keeps the grant until its
// last beat is accepted or MaxBeats beats have gone through, in which case the
// lock is dropped and err_o pulses for one cycle.
//   clk_i, rst_i (sync, active-high), clr_i (sync flush of arbiter state)
//   bus       : request/FIFO handshake (slave modport)
//   gnt_idx_o : selected requester, meaningful while fifo_wvalid is 1
//   locked_o  : packet in progress
//   err_o     : forced release at MaxBeats
module prim_fifo_wr_arb
    import prim_fifo_wr_arb_pkg::*;
#(
    parameter  int unsigned NumReq   = 4,
    parameter  int unsigned Width    = 16,
    parameter  int unsigned MaxBeats = 8,
    localparam int unsigned IdxW     = $clog2(NumReq),
    localparam int unsigned CntW     = $clog2(MaxBeats + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    prim_fifo_wr_arb_if.slave    bus,
    output logic [IdxW-1:0]      gnt_idx_o,
    output logic                 locked_o,
    output logic                 err_o
);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic            err_q, err_d;

    logic [IdxW-1:0] pick_idx;
    logic            pick_any;
    logic [IdxW-1:0] sel;
    logic            wvalid;
    logic            xfer;
    logic            sel_last;
    logic [CntW-1:0] cnt_inc;

    prim_rr_pick #(
        .NumReq (NumReq)
    ) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] x);
        return (x == IdxW'(NumReq - 1)) ? '0 : x + 1'b1;
    endfunction

    always_comb begin
        sel      = (state_q == StLock) ? lock_idx_q : pick_idx;
        wvalid   = (state_q == StLock) ? bus.req_valid[lock_idx_q] : pick_any;
        xfer     = wvalid & bus.fifo_wready;
        sel_last = bus.req_last[sel];
        cnt_inc  = beat_cnt_q + 1'b1;
    end

    // Outputs are forced low while reset is held so the FIFO never sees a
    // write during reset, even with requesters already valid.
    always_comb begin
        bus.fifo_wvalid = wvalid & ~rst_i;
        bus.fifo_wdata  = '0;
        bus.req_ready   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (sel == IdxW'(k) && !rst_i) begin
                bus.fifo_wdata   = bus.req_data[k*Width +: Width];
                bus.req_ready[k] = wvalid & bus.fifo_wready;
            end
        end
        gnt_idx_o = rst_i ? '0 : sel;
        locked_o  = (state_q == StLock) & ~rst_i;
        err_o     = err_q & ~rst_i;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = 1'b0;
        if (xfer) begin
            if (state_q == StIdle) begin
                if (sel_last) begin
                    rr_ptr_d = wrap_inc(sel);
                end else if (MaxBeats == 1) begin
                    // Single-beat limit: the first beat already exhausts the budget.
                    rr_ptr_d = wrap_inc(sel);
                    err_d    = 1'b1;
                end else begin
                    state_d    = StLock;
                    lock_idx_d = sel;
                    beat_cnt_d = CntW'(1);
                end
            end else begin
                beat_cnt_d = cnt_inc;
                if (sel_last || cnt_inc == CntW'(MaxBeats)) begin
                    state_d    = StIdle;
                    rr_ptr_d   = wrap_inc(lock_idx_q);
                    beat_cnt_d = '0;
                    err_d      = ~sel_last;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_prim_fifo_wr_arb.sv
// Bench for prim_fifo_wr_arb: directed scenarios followed by randomized
// packet traffic, all checked against a packet-level reference model.
module tb_prim_fifo_wr_arb;

    localparam int unsigned NumReq   = 4;
    localparam int unsigned Width    = 16;
    localparam int unsigned MaxBeats = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [1:0] gnt;
    logic       locked;
    logic       err;

    always #5 clk = ~clk;

    prim_fifo_wr_arb_if #(.NumReq(NumReq), .Width(Width)) bus ();

    prim_fifo_wr_arb #(
        .NumReq   (NumReq),
        .Width    (Width),
        .MaxBeats (MaxBeats)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (clr),
        .bus       (bus),
        .gnt_idx_o (gnt),
        .locked_o  (locked),
        .err_o     (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port (-1 = nobody), where round-robin
    // resumes, how many beats the owner has sent, and the pending error pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    bit m_err   = 1'b0;

    int xfer_k = -1;
    int rem [NumReq];

    logic [1:0]        obs_gnt;
    logic [NumReq-1:0] obs_ready;
    logic              obs_locked;
    logic              obs_err;
    logic              obs_wvalid;
    logic [Width-1:0]  obs_wdata;
    logic [Width-1:0]  held;

    function automatic int exp_sel();
        if (m_owner >= 0) return m_owner;
        for (int i = 0; i < NumReq; i++) begin
            if (bus.req_valid[(m_ptr + i) % NumReq]) return (m_ptr + i) % NumReq;
        end
        return 0;
    endfunction

    function automatic bit exp_wvalid();
        if (m_owner >= 0) return bus.req_valid[m_owner];
        return |bus.req_valid;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int k, input logic [Width-1:0] v);
        bus.req_data[k*Width +: Width] = v;
    endtask

    // Called just after a rising edge with inputs already set: check the
    // combinational outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int                sel;
        bit                wv;
        bit                lst;
        bit                xf;
        int                beats;
        logic [NumReq-1:0] rdy;
        #3;
        sel        = exp_sel();
        wv         = exp_wvalid();
        obs_gnt    = gnt;
        obs_ready  = bus.req_ready;
        obs_locked = locked;
        obs_err    = err;
        obs_wvalid = bus.fifo_wvalid;
        obs_wdata  = bus.fifo_wdata;
        if (rst) begin
            chk("rst_wvalid", bus.fifo_wvalid, 0);
            chk("rst_ready", bus.req_ready, 0);
            chk("rst_gnt", gnt, 0);
            chk("rst_locked", locked, 0);
            chk("rst_err", err, 0);
        end else begin
            rdy = '0;
            if (wv && bus.fifo_wready) rdy[sel] = 1'b1;
            chk("wvalid", bus.fifo_wvalid, wv);
            chk("ready", bus.req_ready, rdy);
            chk("locked", locked, m_owner >= 0);
            chk("err", err, m_err);
            if (wv) begin
                chk("gnt", gnt, sel);
                chk("wdata", bus.fifo_wdata, bus.req_data[sel*Width +: Width]);
            end
        end
        lst    = bus.req_last[sel];
        xf     = wv && bus.fifo_wready && !rst;
        xfer_k = xf ? sel : -1;
        @(posedge clk);
        if (rst || clr) begin
            m_owner = -1;
            m_ptr   = 0;
            m_beats = 0;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b0;
            if (xf) begin
                beats = ((m_owner >= 0) ? m_beats : 0) + 1;
                if (lst || beats == MaxBeats) begin
                    m_err   = !lst;
                    m_ptr   = (sel + 1) % NumReq;
                    m_owner = -1;
                    m_beats = 0;
                end else begin
                    m_owner = sel;
                    m_beats = beats;
                end
            end
        end
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        clr             = 1'b0;
        bus.req_valid   = '1;
        bus.req_last    = '1;
        bus.req_data    = '0;
        bus.fifo_wready = 1'b1;
        for (int k = 0; k < NumReq; k++) rem[k] = 0;
        @(posedge clk);
        #1;

        // Reset with every requester valid.
        cycle();
        cycle();
        rst = 1'b0;

        // Single-beat packets from all requesters rotate 0,1,2,3,...
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NumReq; k++) set_data(k, Width'($urandom));
            cycle();
            chk("rr_seq", obs_gnt, i % NumReq);
        end

        // Three-beat packet from requester 1 while requester 2 waits.
        bus.req_valid = 4'b0110;
        bus.req_last  = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.req_last[1] = 1'b1;
            set_data(1, Width'($urandom));
            cycle();
            chk("pkt_gnt", obs_gnt, 1);
            chk("pkt_ready2", obs_ready[2], 0);
        end
        cycle();
        chk("pkt_next", obs_gnt, 2);

        // Stall mid-packet on requester 0.
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0000;
        set_data(0, 16'h1234);
        cycle();
        held = 16'hbeef;
        set_data(0, held);
        bus.req_valid   = 4'b1111;
        bus.fifo_wready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_locked", obs_locked, 1);
            chk("stall_wvalid", obs_wvalid, 1);
            chk("stall_wdata", obs_wdata, held);
        end
        bus.fifo_wready = 1'b1;
        bus.req_last    = 4'b0001;
        cycle();
        chk("stall_gnt", obs_gnt, 0);

        // Runaway packet from requester 3.
        bus.req_valid = 4'b1000;
        bus.req_last  = 4'b0000;
        for (int i = 0; i < int'(MaxBeats); i++) begin
            set_data(3, Width'($urandom));
            cycle();
            chk("run_gnt", obs_gnt, 3);
        end
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        cycle();
        chk("run_err", obs_err, 1);
        chk("run_unlocked", obs_locked, 0);
        chk("run_rr0", obs_gnt, 0);
        cycle();
        chk("run_err_pulse", obs_err, 0);

        // Flush while locked on requester 1.
        bus.req_valid = 4'b0010;
        bus.req_last  = 4'b0000;
        cycle();
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        bus.req_valid = 4'b0011;
        cycle();
        chk("clr_unlocked", obs_locked, 0);
        chk("clr_gnt", obs_gnt, 0);

        // Randomized packet traffic with FIFO back-pressure and rare flushes.
        bus.req_valid = '0;
        bus.req_last  = '0;
        for (int n = 0; n < 600; n++) begin
            if (xfer_k >= 0) begin
                rem[xfer_k]--;
                bus.req_valid[xfer_k] = 1'b0;
            end
            for (int k = 0; k < NumReq; k++) begin
                if (!bus.req_valid[k] && ($urandom % 2 == 0)) begin
                    if (rem[k] <= 0) rem[k] = $urandom_range(1, MaxBeats + 2);
                    bus.req_valid[k] = 1'b1;
                    bus.req_last[k]  = (rem[k] == 1);
                    set_data(k, Width'($urandom));
                end
            end
            bus.fifo_wready = ($urandom % 4 != 0);
            clr             = ($urandom % 60 == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
